// File: rtl/conn_pkg.sv
// Shared types and constants for the UART command/response engine.
// The CONN_CHECKSUM_EN macro adds the P_CKSUM parser state.
package conn_pkg;

    typedef enum logic [1:0] {
        P_IDLE,
        P_LOAD1,
        P_LOAD2
`ifdef CONN_CHECKSUM_EN
        , P_CKSUM
`endif
    } parse_state_t;

    typedef enum logic [2:0] {
        T_IDLE,
        T_LOAD,
        T_START,
        T_GAP,
        T_WAIT
    } tx_state_t;

    typedef enum logic [1:0] {
        RSP_OK,
        RSP_ERR,
        RSP_TO,
        RSP_RDY
    } rsp_code_t;

    localparam logic [7:0] CH_LOAD1 = 8'h31;
    localparam logic [7:0] CH_LOAD2 = 8'h32;
    localparam logic [7:0] CH_RUN   = 8'h33;
    localparam logic [7:0] CH_HALT  = 8'h34;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    // Response strings, first character in the low byte; every one ends in LF.
    function automatic logic [7:0] rsp_byte(input rsp_code_t code, input logic [1:0] idx);
        logic [31:0] s;
        case (code)
            RSP_OK:  s = {8'h00, ASCII_LF, 8'h4B, 8'h4F};
            RSP_ERR: s = {ASCII_LF, 8'h52, 8'h52, 8'h45};
            RSP_TO:  s = {8'h00, ASCII_LF, 8'h4F, 8'h54};
            default: s = {ASCII_LF, 8'h59, 8'h44, 8'h52};
        endcase
        return s[8*idx +: 8];
    endfunction

endpackage

// File: rtl/conn_tx_seq.sv
// Byte sender: picks the response slot over a pending message, walks the
// bytes through the transmitter handshake and terminates on LF.
module conn_tx_seq
    import conn_pkg::*;
#(
    parameter int MSG_BYTES = 32
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   rsp_full,
    input  rsp_code_t              rsp_code,
    input  logic                   msg_pending,
    input  logic [8*MSG_BYTES-1:0] msg_buf,
    input  logic                   tx_busy,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    output logic                   rsp_done,
    output logic                   msg_done,
    output logic                   active
);
    localparam int IW = $clog2(MSG_BYTES + 1);

    tx_state_t     state_reg, state_next;
    logic          src_rsp_reg, src_rsp_next;
    logic [IW-1:0] idx_reg, idx_next;
    logic [7:0]    data_reg, data_next;
    logic [7:0]    cur_byte;

    // A message that never contains LF gets one appended after MSG_BYTES bytes.
    always_comb begin
        if (src_rsp_reg)
            cur_byte = rsp_byte(rsp_code, idx_reg[1:0]);
        else if (idx_reg == IW'(MSG_BYTES))
            cur_byte = ASCII_LF;
        else
            cur_byte = msg_buf[8*idx_reg +: 8];
    end

    always_comb begin
        state_next   = state_reg;
        src_rsp_next = src_rsp_reg;
        idx_next     = idx_reg;
        data_next    = data_reg;
        tx_start     = 1'b0;
        rsp_done     = 1'b0;
        msg_done     = 1'b0;
        case (state_reg)
            T_IDLE: begin
                if (rsp_full || msg_pending) begin
                    src_rsp_next = rsp_full;
                    idx_next     = '0;
                    state_next   = T_LOAD;
                end
            end
            T_LOAD: begin
                data_next  = cur_byte;
                state_next = T_START;
            end
            T_START: begin
                if (!tx_busy) begin
                    tx_start   = 1'b1;
                    state_next = T_GAP;
                end
            end
            T_GAP: state_next = T_WAIT;
            T_WAIT: begin
                if (!tx_busy) begin
                    if (data_reg == ASCII_LF) begin
                        rsp_done   = src_rsp_reg;
                        msg_done   = !src_rsp_reg;
                        state_next = T_IDLE;
                    end else begin
                        idx_next   = idx_reg + IW'(1);
                        state_next = T_LOAD;
                    end
                end
            end
            default: state_next = T_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg   <= T_IDLE;
            src_rsp_reg <= 1'b0;
            idx_reg     <= '0;
            data_reg    <= 8'h00;
        end else begin
            state_reg   <= state_next;
            src_rsp_reg <= src_rsp_next;
            idx_reg     <= idx_next;
            data_reg    <= data_next;
        end
    end

    assign tx_data = data_reg;
    assign active  = (state_reg != T_IDLE);

endmodule

// File: rtl/conn_cmd_engine.sv
// UART command parser with shadowed block loads, atomic commit, inter-byte
// timeout and a one-deep response slot. CONN_CHECKSUM_EN adds an XOR check byte.
module conn_cmd_engine
    import conn_pkg::*;
#(
    parameter int BLK1_BYTES     = 64,
    parameter int BLK2_BYTES     = 12,
    parameter int MSG_BYTES      = 32,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter logic [8*BLK1_BYTES-1:0] BLK1_INIT = '0,
    parameter logic [8*BLK2_BYTES-1:0] BLK2_INIT = '0
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_busy,
    input  logic [8*MSG_BYTES-1:0]  msg,
    input  logic                    msg_valid,
    output logic                    miner_en,
    output logic [8*BLK1_BYTES-1:0] blk1,
    output logic [8*BLK2_BYTES-1:0] blk2,
    output logic                    blk_update,
    output logic                    rx_led,
    output logic                    tx_led,
    output logic [7:0]              overrun_cnt
);
    localparam int MAXB = (BLK1_BYTES > BLK2_BYTES) ? BLK1_BYTES : BLK2_BYTES;
    localparam int IDXW = (MAXB > 1) ? $clog2(MAXB) : 1;

    parse_state_t            state_reg, state_next;
    logic [IDXW-1:0]         idx_reg, last_idx;
    logic [8*BLK1_BYTES-1:0] shadow1_reg, blk1_reg;
    logic [8*BLK2_BYTES-1:0] shadow2_reg, blk2_reg;
    logic [31:0]             gap_reg;
    logic                    commit1_reg, commit1_next, commit2_reg, commit2_next;
    logic                    miner_en_reg, miner_en_next;
    logic                    blk_update_reg, rx_led_reg;
    logic                    load_start, load_write, timeout, commit_any;
    logic                    rsp_p, rsp_new, rsp_drop;
    rsp_code_t               code_p, rsp_code_new, rsp_code_reg;
    logic                    boot_reg, rsp_full_reg;
    logic [7:0]              overrun_reg;
    logic                    msg_valid_d_reg, msg_pending_reg;
    logic [8*MSG_BYTES-1:0]  msg_buf_reg;
    logic                    rsp_done, msg_done, tx_active;
`ifdef CONN_CHECKSUM_EN
    logic [7:0]              cksum_reg;
    logic                    load_sel_reg;
`endif

    assign last_idx = (state_reg == P_LOAD1) ? IDXW'(BLK1_BYTES - 1) : IDXW'(BLK2_BYTES - 1);
    assign timeout  = (state_reg != P_IDLE) && (gap_reg == 32'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_next    = state_reg;
        miner_en_next = miner_en_reg;
        commit1_next  = 1'b0;
        commit2_next  = 1'b0;
        load_start    = 1'b0;
        load_write    = 1'b0;
        rsp_p         = 1'b0;
        code_p        = RSP_OK;
        case (state_reg)
            P_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        CH_LOAD1: begin state_next = P_LOAD1; load_start = 1'b1; end
                        CH_LOAD2: begin state_next = P_LOAD2; load_start = 1'b1; end
                        CH_RUN:   begin miner_en_next = 1'b1; rsp_p = 1'b1; end
                        CH_HALT:  begin miner_en_next = 1'b0; rsp_p = 1'b1; end
                        ASCII_CR, ASCII_LF: ;
                        default:  begin rsp_p = 1'b1; code_p = RSP_ERR; end
                    endcase
                end
            end
            P_LOAD1, P_LOAD2: begin
                if (rx_valid) begin
                    load_write = 1'b1;
                    if (idx_reg == last_idx) begin
`ifdef CONN_CHECKSUM_EN
                        state_next = P_CKSUM;
`else
                        commit1_next = (state_reg == P_LOAD1);
                        commit2_next = (state_reg == P_LOAD2);
                        state_next   = P_IDLE;
`endif
                    end
                end else if (timeout) begin
                    rsp_p      = 1'b1;
                    code_p     = RSP_TO;
                    state_next = P_IDLE;
                end
            end
`ifdef CONN_CHECKSUM_EN
            P_CKSUM: begin
                if (rx_valid) begin
                    state_next = P_IDLE;
                    if (rx_data == cksum_reg) begin
                        commit1_next = !load_sel_reg;
                        commit2_next = load_sel_reg;
                    end else begin
                        rsp_p  = 1'b1;
                        code_p = RSP_ERR;
                    end
                end else if (timeout) begin
                    rsp_p      = 1'b1;
                    code_p     = RSP_TO;
                    state_next = P_IDLE;
                end
            end
`endif
            default: state_next = P_IDLE;
        endcase
    end

    // The commit's OK wins over a parser response raised in the same cycle.
    assign commit_any   = commit1_reg | commit2_reg;
    assign rsp_new      = commit_any | rsp_p;
    assign rsp_code_new = commit_any ? RSP_OK : code_p;
    assign rsp_drop     = (rsp_new && (rsp_full_reg || boot_reg)) || (commit_any && rsp_p);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg      <= P_IDLE;
            miner_en_reg   <= 1'b0;
            commit1_reg    <= 1'b0;
            commit2_reg    <= 1'b0;
            idx_reg        <= '0;
            gap_reg        <= '0;
            shadow1_reg    <= '0;
            shadow2_reg    <= '0;
            blk1_reg       <= BLK1_INIT;
            blk2_reg       <= BLK2_INIT;
            blk_update_reg <= 1'b0;
            rx_led_reg     <= 1'b0;
`ifdef CONN_CHECKSUM_EN
            cksum_reg      <= 8'h00;
            load_sel_reg   <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            miner_en_reg   <= miner_en_next;
            commit1_reg    <= commit1_next;
            commit2_reg    <= commit2_next;
            blk_update_reg <= commit_any;
            if (rx_valid)
                rx_led_reg <= !rx_led_reg;
            if (rx_valid || state_reg == P_IDLE)
                gap_reg <= '0;
            else
                gap_reg <= gap_reg + 32'd1;
            if (load_start)
                idx_reg <= '0;
            else if (load_write)
                idx_reg <= idx_reg + IDXW'(1);
            if (load_write && state_reg == P_LOAD1)
                shadow1_reg[8*idx_reg +: 8] <= rx_data;
            if (load_write && state_reg == P_LOAD2)
                shadow2_reg[8*idx_reg +: 8] <= rx_data;
            if (commit1_reg)
                blk1_reg <= shadow1_reg;
            if (commit2_reg)
                blk2_reg <= shadow2_reg;
`ifdef CONN_CHECKSUM_EN
            if (load_start) begin
                cksum_reg    <= 8'h00;
                load_sel_reg <= (rx_data == CH_LOAD2);
            end else if (load_write) begin
                cksum_reg <= cksum_reg ^ rx_data;
            end
`endif
        end
    end

    // The slot stays full until its last byte has gone, so a busy slot drops.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            boot_reg        <= 1'b1;
            rsp_full_reg    <= 1'b0;
            rsp_code_reg    <= RSP_OK;
            overrun_reg     <= 8'h00;
            msg_valid_d_reg <= 1'b0;
            msg_pending_reg <= 1'b0;
            msg_buf_reg     <= '0;
        end else begin
            if (boot_reg) begin
                boot_reg     <= 1'b0;
                rsp_full_reg <= 1'b1;
                rsp_code_reg <= RSP_RDY;
            end else if (rsp_new && !rsp_full_reg) begin
                rsp_full_reg <= 1'b1;
                rsp_code_reg <= rsp_code_new;
            end else if (rsp_done) begin
                rsp_full_reg <= 1'b0;
            end
            if (rsp_drop && overrun_reg != 8'hFF)
                overrun_reg <= overrun_reg + 8'd1;
            msg_valid_d_reg <= msg_valid;
            if (msg_valid && !msg_valid_d_reg && !msg_pending_reg) begin
                msg_pending_reg <= 1'b1;
                msg_buf_reg     <= msg;
            end else if (msg_done) begin
                msg_pending_reg <= 1'b0;
            end
        end
    end

    conn_tx_seq #(
        .MSG_BYTES (MSG_BYTES)
    ) u_tx_seq (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .rsp_full    (rsp_full_reg),
        .rsp_code    (rsp_code_reg),
        .msg_pending (msg_pending_reg),
        .msg_buf     (msg_buf_reg),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .rsp_done    (rsp_done),
        .msg_done    (msg_done),
        .active      (tx_active)
    );

    assign miner_en    = miner_en_reg;
    assign blk1        = blk1_reg;
    assign blk2        = blk2_reg;
    assign blk_update  = blk_update_reg;
    assign rx_led      = rx_led_reg;
    assign tx_led      = tx_active;
    assign overrun_cnt = overrun_reg;

endmodule

// File: tb/tb_conn_cmd_engine.sv
// Directed bench for conn_cmd_engine with a small transmitter model;
// the checksum cases run only when CONN_CHECKSUM_EN is defined.
module tb_conn_cmd_engine;
    localparam int B1 = 64;
    localparam int B2 = 12;
    localparam int MB = 32;
    localparam logic [8*B1-1:0] INIT1 = {16{32'hDEADBEEF}};
    localparam logic [8*B2-1:0] INIT2 = {3{32'h01234567}};

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic [8*MB-1:0] msg;
    logic          msg_valid;
    logic          miner_en;
    logic [8*B1-1:0] blk1;
    logic [8*B2-1:0] blk2;
    logic          blk_update;
    logic          rx_led;
    logic          tx_led;
    logic [7:0]    overrun_cnt;

    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int busy_left = 0;
    int n_rx = 0;
    logic [7:0] tx_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    conn_cmd_engine #(
        .BLK1_BYTES     (B1),
        .BLK2_BYTES     (B2),
        .MSG_BYTES      (MB),
        .TIMEOUT_CYCLES (100),
        .BLK1_INIT      (INIT1),
        .BLK2_INIT      (INIT2)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .msg         (msg),
        .msg_valid   (msg_valid),
        .miner_en    (miner_en),
        .blk1        (blk1),
        .blk2        (blk2),
        .blk_update  (blk_update),
        .rx_led      (rx_led),
        .tx_led      (tx_led),
        .overrun_cnt (overrun_cnt)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: latches each started byte and stays busy for 6 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge CLOCK_50);
            if (tx_start) begin
                check_val("tx_start_idle", tx_busy, 0);
                $display("tx byte %02h", tx_data);
                tx_q.push_back(tx_data);
                tx_busy = 1'b1;
                busy_left = 6;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0)
                    tx_busy = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge CLOCK_50);
            if (blk_update)
                upd_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLOCK_50);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
        n_rx++;
        repeat (2) @(negedge CLOCK_50);
    endtask

    task automatic expect_tx(input string tag, input string exp, input bit wait_idle);
        int n;
        n = 0;
        while (tx_q.size() < exp.len() && n < 3000) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (tx_q.size() < exp.len()) begin
            check_val({tag, "_len"}, 64'(tx_q.size()), 64'(exp.len()));
            tx_q.delete();
            return;
        end
        for (int i = 0; i < exp.len(); i++) begin
            logic [7:0] b;
            b = tx_q.pop_front();
            check_val(tag, b, exp[i]);
        end
        if (wait_idle) begin
            n = 0;
            while (tx_led && n < 3000) begin
                @(negedge CLOCK_50);
                n++;
            end
            check_val({tag, "_idle"}, tx_led, 0);
        end
    endtask

    initial begin
        logic [7:0]      x;
        logic [8*B2-1:0] e2;
        int              n;
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        msg       = '0;
        msg_valid = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_miner_en", miner_en, 0);
        check_val("rst_overrun", overrun_cnt, 0);
        check_val("rst_blk_update", blk_update, 0);
        check_val("rst_leds", {rx_led, tx_led, tx_start}, 0);
        check_val("rst_blk1", 64'(blk1 == INIT1), 1);
        reset = 1'b0;

        expect_tx("banner", "RDY\n", 1);
        check_val("blk1_init", 64'(blk1 == INIT1), 1);

        send_byte(8'h31);
        for (int i = 0; i < B1; i++)
            send_byte(8'(i));
`ifdef CONN_CHECKSUM_EN
        send_byte(8'h00);
`endif
        expect_tx("load1_ok", "OK\n", 1);
        check_val("blk1_lo", blk1[7:0], 8'h00);
        check_val("blk1_hi", blk1[511:504], 8'h3F);
        check_val("blk1_mid", blk1[263:256], 8'h20);
        check_val("upd_once", upd_cnt, 1);
        check_val("blk2_untouched", 64'(blk2 == INIT2), 1);

        send_byte(8'h32);
        for (int i = 0; i < 5; i++)
            send_byte(8'hA0 + 8'(i));
        expect_tx("timeout", "TO\n", 1);
        check_val("blk2_after_to", 64'(blk2 == INIT2), 1);
        check_val("upd_after_to", upd_cnt, 1);
        send_byte(8'h33);
        expect_tx("run_ok", "OK\n", 1);
        check_val("miner_on", miner_en, 1);

        send_byte(8'h78);
        expect_tx("bad_cmd", "ERR\n", 1);
        send_byte(8'h0D);
        send_byte(8'h0A);
        repeat (100) @(negedge CLOCK_50);
        check_val("crlf_quiet", 64'(tx_q.size()), 0);
        check_val("crlf_tx_led", tx_led, 0);

        msg[31:0] = 32'h0A636261;
        @(negedge CLOCK_50);
        rx_data   = 8'h34;
        rx_valid  = 1'b1;
        msg_valid = 1'b1;
        @(negedge CLOCK_50);
        rx_valid = 1'b0;
        n_rx++;
        expect_tx("rsp_first", "OK\n", 0);
        n = 0;
        while (tx_q.size() == 0 && n < 1000) begin
            @(negedge CLOCK_50);
            n++;
        end
        check_val("msg_started", 64'(tx_q.size() > 0), 1);
        send_byte(8'h33);
        send_byte(8'h34);
        expect_tx("msg_then_ok", "abc\nOK\n", 1);
        check_val("miner_off", miner_en, 0);
        check_val("overrun_one", overrun_cnt, 1);
        msg_valid = 1'b0;

`ifdef CONN_CHECKSUM_EN
        x = 8'h00;
        e2 = '0;
        for (int i = 0; i < B2; i++) begin
            e2[8*i +: 8] = 8'h10 + 8'(i);
            x = x ^ (8'h10 + 8'(i));
        end
        send_byte(8'h32);
        for (int i = 0; i < B2; i++)
            send_byte(8'h10 + 8'(i));
        send_byte(x ^ 8'hFF);
        expect_tx("cksum_bad", "ERR\n", 1);
        check_val("blk2_no_commit", 64'(blk2 == INIT2), 1);
        send_byte(8'h32);
        for (int i = 0; i < B2; i++)
            send_byte(8'h10 + 8'(i));
        send_byte(x);
        expect_tx("cksum_ok", "OK\n", 1);
        check_val("blk2_commit", 64'(blk2 == e2), 1);
        check_val("upd_cksum", upd_cnt, 2);
`else
        x  = 8'h00;
        e2 = '0;
`endif
        check_val("rx_led_parity", rx_led, 64'(n_rx % 2));
        check_val("overrun_final", overrun_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conn_cmd_engine.md
Name: conn_cmd_engine

Overview:
- Parametrised UART command/response engine between the byte-level async_receiver/async_transmitter pair and the miner core.
- Parses single-character commands, loads full-width work blocks through shadow buffers, drives miner enable, and returns framed ASCII responses.
- Forwards asynchronous result messages from the miner.
- Successor to the fixed-width connection core: full-length block loads, atomic commit, inter-byte timeout, response overrun tracking.

Parameters:
- BLK1_BYTES, 64, payload bytes for command '1'; blk1 width = 8*BLK1_BYTES
- BLK2_BYTES, 12, payload bytes for command '2'; blk2 width = 8*BLK2_BYTES
- MSG_BYTES, 32, maximum forwarded message length
- TIMEOUT_CYCLES, 50000000, idle cycles allowed between payload bytes
- BLK1_INIT / BLK2_INIT, genesis header words, reset values of blk1/blk2

Ports:
- CLOCK_50  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- rx_valid  in  1  one-cycle strobe from async_receiver
- rx_data  in  8  received byte
- tx_start  out  1  one-cycle start strobe to async_transmitter
- tx_data  out  8  byte to transmit; stable while tx_start is high
- tx_busy  in  1  transmitter busy
- msg  in  8*MSG_BYTES  outbound message; byte 0 is in [7:0]
- msg_valid  in  1  level; its rising edge queues msg
- miner_en  out  1  miner run enable
- blk1  out  8*BLK1_BYTES  committed block 1
- blk2  out  8*BLK2_BYTES  committed block 2
- blk_update  out  1  one-cycle pulse on any commit
- rx_led / tx_led  out  1  activity indicators
- overrun_cnt  out  8  dropped-response counter, saturating

Behaviour:
- Reset values:
  - blk1=BLK1_INIT, blk2=BLK2_INIT.
  - miner_en, tx_start, blk_update, rx_led, tx_led, overrun_cnt all 0.
  - Parser in P_IDLE; shadow and pending flags cleared.
- Reset release: the banner "RDY\n" is queued as the first response. Reset mid-transfer aborts the current byte immediately.
- Parser FSM states P_IDLE, P_LOAD1, P_LOAD2.
- P_IDLE byte handling:
  - '1' -> P_LOAD1, idx=0
  - '2' -> P_LOAD2, idx=0
  - '3' -> miner_en=1, response OK
  - '4' -> miner_en=0, response OK
  - 0x0D/0x0A -> ignored, no response
  - any other byte -> response ERR
- P_LOADn:
  - Each rx_valid writes rx_data into shadow[8*idx +: 8] (little-endian; first byte -> [7:0]), then idx++.
  - When idx reaches BLKn_BYTES-1 and that byte is written: on the next cycle, blkn <= shadow (all bits in one cycle), blk_update pulses for 1 cycle, response OK, state -> P_IDLE.
- Timeout:
  - The gap counter resets on every rx_valid.
  - In P_LOADn, gap reaching TIMEOUT_CYCLES -> shadow discarded, blkn unchanged, response "TO\n", state -> P_IDLE.
  - The gap counter does not run in P_IDLE.
- Responses are ASCII, sent first byte first: OK="OK\n", ERR="ERR\n", TO="TO\n".
- Response slot (depth 1):
  - A new response arriving while the slot is full or its message is being transmitted is dropped and overrun_cnt increments; overrun_cnt saturates at 255.
  - The command's side effects still apply when its response is dropped.
- Message queueing:
  - A rising edge of msg_valid sets msg_pending and snapshots msg.
  - Transmission sends bytes in order until the first 0x0A, or MSG_BYTES bytes are sent; 0x0A is then appended if not already sent.
  - A second msg_valid edge while msg_pending is set is ignored.
- Arbitration: when idle, the TX sequencer picks the response slot before msg_pending. A message that has started is never interrupted.
- TX handshake, per byte:
  - T_LOAD: drive tx_data.
  - T_START: tx_start=1 for exactly 1 cycle, issued only when tx_busy=0.
  - T_GAP: 1 cycle, tx_busy ignored.
  - T_WAIT: hold until tx_busy=0.
  - Next byte follows, or return to T_IDLE.
- rx_led toggles on each rx_valid. tx_led is high while the TX sequencer is not idle.
- RX parsing runs concurrently with TX; no input byte is ever lost.

Optional Feature:
- CONN_CHECKSUM_EN. When defined:
  - Each load expects one additional byte equal to the XOR of all payload bytes (state P_CKSUM).
  - Match -> commit plus OK.
  - Mismatch -> no commit, response ERR.
  - The timeout also applies in P_CKSUM.
- When not defined: commit follows the last payload byte directly; no P_CKSUM state exists.

Decomposition:
- Package conn_pkg holds:
  - parser/TX state enums
  - response code enum (RSP_OK, RSP_ERR, RSP_TO, RSP_RDY)
  - ASCII constants for the command characters and 0x0A/0x0D
  - response string ROM function
- Sub-module conn_tx_seq: byte-buffer sender implementing arbitration, the T_* handshake and 0x0A termination. The top level keeps the parser, shadow buffers and counters.

Test Plan:
- Reset release -> bytes 'R','D','Y',0x0A on tx_data, one tx_start each, each only while tx_busy=0; blk1=BLK1_INIT.
- '1' followed by 64 bytes 0x00..0x3F -> blk1[7:0]=0x00, blk1[511:504]=0x3F; single blk_update pulse; "OK\n".
- '2' followed by 5 bytes, then silence for TIMEOUT_CYCLES (bench TIMEOUT_CYCLES=100) -> blk2 unchanged, "TO\n", parser back in P_IDLE; a following '3' sets miner_en=1 and returns "OK\n".
- Byte 'x' -> "ERR\n". Bytes 0x0D,0x0A -> no TX activity.
- msg="abc\n" with msg_valid rising in the same cycle an OK response is created -> "OK\n" is sent first, then "abc\n". '3' and '4' sent back-to-back during TX -> miner_en ends 0, overrun_cnt=1.
- With CONN_CHECKSUM_EN defined: '2' + 12 bytes + wrong XOR -> ERR, blk2 unchanged; repeated with the correct XOR -> commit and OK.
